// File: rtl/configPackage.sv
// Shared types and constants for the RISC-V memory channel arbiter.
package configPackage;

  localparam int RV_ADDR_W = 20;
  localparam int RV_DATA_W = 16;
  localparam int RV_DS_W   = 2;
  localparam int WCNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } rv_arb_state_t;

  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
    return (v == {WCNT_W{1'b1}}) ? v : v + {{(WCNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the search starts one past the last winner.
module rr_arbiter #(
  parameter  int N     = 3,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IDX_W'((int'(last) + off) % N);
      if (!found && req[cand]) begin
        found      = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller's RISC-V toggle-handshake
// channel between I-fetch, data and loader requesters.
module rv_mem_arbiter
  import configPackage::*;
#(
  parameter int NPORT       = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NPORT-1:0]            m_valid,
  input  logic [NPORT-1:0]            m_we,
  input  logic [NPORT*RV_ADDR_W-1:0]  m_addr,
  input  logic [NPORT*RV_DATA_W-1:0]  m_din,
  input  logic [NPORT*RV_DS_W-1:0]    m_ds,
  output logic [NPORT-1:0]            m_ready,
  output logic [RV_DATA_W-1:0]        m_dout,
  output logic [RV_ADDR_W-1:0]        rv_addr,
  output logic [RV_DATA_W-1:0]        rv_din,
  output logic [RV_DS_W-1:0]          rv_ds,
  output logic                        rv_we,
  output logic                        rv_req,
  input  logic                        rv_req_ack,
  input  logic [RV_DATA_W-1:0]        rv_dout,
  output logic                        busy,
  output logic                        err_timeout
);

  localparam int          IDX_W  = $clog2(NPORT);
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYC);

  rv_arb_state_t state, state_nxt;

  logic [IDX_W-1:0]     grant;
  logic [IDX_W-1:0]     last;
  logic [IDX_W-1:0]     win_idx;
  logic [NPORT-1:0]     win_oh;
  logic [WCNT_W-1:0]    wait_cnt;
  logic [WCNT_W-1:0]    wait_cnt_inc;
  logic                 ack_match;
  logic                 any_valid;
  logic                 take;

  logic [RV_ADDR_W-1:0] sel_addr;
  logic [RV_DATA_W-1:0] sel_din;
  logic [RV_DS_W-1:0]   sel_ds;
  logic                 sel_we;

  rr_arbiter #(.N(NPORT)) u_rr (
    .req     (m_valid),
    .last    (last),
    .gnt     (win_oh),
    .gnt_idx (win_idx)
  );

  assign any_valid    = |m_valid;
  assign ack_match    = (rv_req_ack == rv_req);
  assign take         = (state == IDLE) && any_valid;
  assign wait_cnt_inc = sat_inc(wait_cnt);

  // One-hot AND-OR mux of the winning port's request fields
  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_ds   = '0;
    sel_we   = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (win_oh[i]) begin
        sel_addr = sel_addr | m_addr[i*RV_ADDR_W +: RV_ADDR_W];
        sel_din  = sel_din  | m_din[i*RV_DATA_W +: RV_DATA_W];
        sel_ds   = sel_ds   | m_ds[i*RV_DS_W +: RV_DS_W];
        sel_we   = sel_we   | m_we[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = WAIT;
      WAIT:    if (ack_match) state_nxt = rv_we ? DONE : CAPT;
      CAPT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and toggle: rv_* stay frozen from one grant to the next
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rv_addr <= '0;
      rv_din  <= '0;
      rv_ds   <= '0;
      rv_we   <= 1'b0;
      rv_req  <= 1'b0;
      grant   <= '0;
      last    <= IDX_W'(NPORT - 1);
    end else if (take) begin
      rv_addr <= sel_addr;
      rv_din  <= sel_din;
      rv_ds   <= sel_ds;
      rv_we   <= sel_we;
      rv_req  <= ~rv_req;
      grant   <= win_idx;
      last    <= win_idx;
    end
  end

  // The toggle pair cannot be resynchronised, so a timeout only flags and keeps waiting
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else if (take) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !ack_match) begin
      wait_cnt <= wait_cnt_inc;
      if ({16'd0, wait_cnt_inc} >= TO_LIM) begin
        err_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_dout <= '0;
    end else if (state == CAPT) begin
      m_dout <= rv_dout;
    end
  end

  always_comb begin
    m_ready = '0;
    if (state == DONE) begin
      m_ready[grant] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter with a toggle-handshake SDRAM model.
module tb_rv_mem_arbiter;

  localparam int NP = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn;
  logic [NP-1:0]     m_valid, m_we, m_ready;
  logic [NP*20-1:0]  m_addr;
  logic [NP*16-1:0]  m_din;
  logic [NP*2-1:0]   m_ds;
  logic [15:0]       m_dout, rv_din, rv_dout;
  logic [19:0]       rv_addr;
  logic [1:0]        rv_ds;
  logic              rv_we, rv_req, rv_req_ack, busy, err_timeout;

  logic [NP-1:0]     t_valid, t_we, t_ready;
  logic [NP*20-1:0]  t_addr;
  logic [NP*16-1:0]  t_din;
  logic [NP*2-1:0]   t_ds;
  logic [15:0]       t_dout, t_rv_din, t_rv_dout;
  logic [19:0]       t_rv_addr;
  logic [1:0]        t_rv_ds;
  logic              t_rv_we, t_rv_req, t_ack, t_busy, t_err;

  rv_mem_arbiter #(.NPORT(NP), .TIMEOUT_CYC(1024)) dut (
    .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr),
    .m_din(m_din), .m_ds(m_ds), .m_ready(m_ready), .m_dout(m_dout),
    .rv_addr(rv_addr), .rv_din(rv_din), .rv_ds(rv_ds), .rv_we(rv_we),
    .rv_req(rv_req), .rv_req_ack(rv_req_ack), .rv_dout(rv_dout),
    .busy(busy), .err_timeout(err_timeout)
  );

  rv_mem_arbiter #(.NPORT(NP), .TIMEOUT_CYC(8)) dut_to (
    .clk(clk), .resetn(resetn), .m_valid(t_valid), .m_we(t_we), .m_addr(t_addr),
    .m_din(t_din), .m_ds(t_ds), .m_ready(t_ready), .m_dout(t_dout),
    .rv_addr(t_rv_addr), .rv_din(t_rv_din), .rv_ds(t_rv_ds), .rv_we(t_rv_we),
    .rv_req(t_rv_req), .rv_req_ack(t_ack), .rv_dout(t_rv_dout),
    .busy(t_busy), .err_timeout(t_err)
  );

  // SDRAM model: acks ack_delay cycles after seeing a new toggle
  logic [15:0] mem [0:1023];
  int ack_delay;
  int dly;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rv_req_ack <= 1'b0;
      rv_dout    <= 16'h0;
      dly        <= 0;
    end else if (rv_req != rv_req_ack) begin
      if (dly >= ack_delay) begin
        rv_req_ack <= rv_req;
        dly        <= 0;
        if (rv_we) begin
          if (rv_ds[1]) mem[rv_addr[9:0]][15:8] <= rv_din[15:8];
          if (rv_ds[0]) mem[rv_addr[9:0]][7:0]  <= rv_din[7:0];
        end else begin
          rv_dout <= mem[rv_addr[9:0]];
        end
      end else begin
        dly <= dly + 1;
      end
    end
  end

  int   tog_cnt = 0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (rv_req !== prev_req) tog_cnt <= tog_cnt + 1;
    prev_req <= rv_req;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input int p, input logic we, input logic [19:0] a,
                        input logic [15:0] d, input logic [1:0] ds,
                        output int lat, output logic [15:0] rd, output logic we1,
                        output logic [19:0] a1, output logic busy_ok);
    @(negedge clk);
    m_we[p]           = we;
    m_addr[p*20 +: 20] = a;
    m_din[p*16 +: 16]  = d;
    m_ds[p*2 +: 2]     = ds;
    m_valid           = '0;
    m_valid[p]        = 1'b1;
    lat = -1; rd = '0; we1 = 1'b0; a1 = '0; busy_ok = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        we1 = rv_we;
        a1  = rv_addr;
      end
      if (m_ready != '0) begin
        lat = c;
        rd  = m_dout;
        check_val("ready_onehot", 32'(m_ready), 32'(1 << p));
        m_valid[p] = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  int          lat, t0, idx, found;
  logic [15:0] rd;
  logic        we1, bok;
  logic [19:0] a1;
  int          rr_got[$];
  int          rr_exp[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    resetn = 1'b0; m_valid = '0; m_we = '0; m_addr = '0; m_din = '0; m_ds = '0;
    t_valid = '0; t_we = '0; t_addr = '0; t_din = '0; t_ds = '0; t_rv_dout = '0; t_ack = 1'b0;
    ack_delay = 0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_req", 32'(rv_req), 32'd0);
    check_val("rst_addr", 32'(rv_addr), 32'd0);
    check_val("rst_we", 32'(rv_we), 32'd0);
    check_val("rst_ready", 32'(m_ready), 32'd0);
    check_val("rst_dout", 32'(m_dout), 32'd0);
    check_val("rst_err", 32'(err_timeout), 32'd0);
    resetn = 1'b1;

    // Round-robin: three writers held valid, six transactions
    @(negedge clk);
    t0 = tog_cnt;
    m_we = 3'b111; m_ds = 6'b111111;
    m_addr = {20'h00100, 20'h00011, 20'h00010};
    m_din  = {16'hBEEF, 16'h2222, 16'h1111};
    m_valid = 3'b111;
    for (int c = 0; c < 200 && rr_got.size() < 6; c++) begin
      @(negedge clk);
      if (m_ready != '0) begin
        check_val("rr_onehot", 32'($countones(m_ready)), 32'd1);
        idx = 0;
        for (int i = 0; i < NP; i++) if (m_ready[i]) idx = i;
        rr_got.push_back(idx);
        if (rr_got.size() == 6) m_valid = '0;
      end
    end
    check_val("rr_count", 32'(rr_got.size()), 32'd6);
    for (int i = 0; i < 6 && i < rr_got.size(); i++) check_val("rr_order", 32'(rr_got[i]), 32'(rr_exp[i]));
    check_val("rr_toggles", 32'(tog_cnt - t0), 32'd6);

    // Single read
    t0 = tog_cnt;
    do_req(1, 1'b0, 20'h00100, 16'h0, 2'b11, lat, rd, we1, a1, bok);
    check_val("rd_lat", 32'(lat), 32'd4);
    check_val("rd_data", 32'(rd), 32'hBEEF);
    check_val("rd_addr", 32'(a1), 32'h00100);
    check_val("rd_we", 32'(we1), 32'd0);
    check_val("rd_toggles", 32'(tog_cnt - t0), 32'd1);

    // Write then read back; write must not disturb m_dout
    do_req(0, 1'b1, 20'h00020, 16'h1234, 2'b11, lat, rd, we1, a1, bok);
    check_val("wr_lat", 32'(lat), 32'd3);
    check_val("wr_we", 32'(we1), 32'd1);
    check_val("wr_dout_hold", 32'(rd), 32'hBEEF);
    do_req(0, 1'b0, 20'h00020, 16'h0, 2'b11, lat, rd, we1, a1, bok);
    check_val("rb_lat", 32'(lat), 32'd4);
    check_val("rb_data", 32'(rd), 32'h1234);

    // Low-byte-only write
    do_req(2, 1'b1, 20'h00020, 16'hABCD, 2'b01, lat, rd, we1, a1, bok);
    do_req(2, 1'b0, 20'h00020, 16'h0, 2'b11, lat, rd, we1, a1, bok);
    check_val("ds_lo_data", 32'(rd), 32'h12CD);

    // Delayed ack: ack lands in WAIT cycle 10
    ack_delay = 8;
    do_req(1, 1'b0, 20'h00020, 16'h0, 2'b11, lat, rd, we1, a1, bok);
    ack_delay = 0;
    check_val("dly_lat", 32'(lat), 32'd12);
    check_val("dly_data", 32'(rd), 32'h12CD);
    check_val("dly_busy", 32'(bok), 32'd1);
    check_val("dly_no_err", 32'(err_timeout), 32'd0);

    // Timeout on the TIMEOUT_CYC=8 instance
    @(negedge clk);
    t_we = 3'b001; t_ds = 6'b000011; t_valid = 3'b001;
    repeat (8) @(negedge clk);
    check_val("to_not_yet", 32'(t_err), 32'd0);
    @(negedge clk);
    check_val("to_set", 32'(t_err), 32'd1);
    repeat (3) @(negedge clk);
    check_val("to_sticky", 32'(t_err), 32'd1);
    check_val("to_busy", 32'(t_busy), 32'd1);
    t_ack = t_rv_req;
    @(negedge clk);
    check_val("to_late_ready", 32'(t_ready), 32'd1);
    t_valid = '0;
    @(negedge clk);
    check_val("to_idle", 32'(t_busy), 32'd0);
    check_val("to_err_held", 32'(t_err), 32'd1);

    // Reset in the middle of WAIT on a port-0 request
    @(negedge clk);
    ack_delay = 1000;
    m_we = '0; m_addr[0 +: 20] = 20'h00100; m_valid = 3'b001;
    repeat (4) @(negedge clk);
    check_val("mid_busy_pre", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_req", 32'(rv_req), 32'd0);
    check_val("mid_rst_addr", 32'(rv_addr), 32'd0);
    check_val("mid_rst_dout", 32'(m_dout), 32'd0);
    check_val("mid_rst_terr", 32'(t_err), 32'd0);
    t_ack = 1'b0;
    ack_delay = 0;
    m_we = 3'b111; m_valid = 3'b111;
    repeat (2) @(negedge clk);
    check_val("mid_rst_ready", 32'(m_ready), 32'd0);
    resetn = 1'b1;
    found = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (m_ready != '0) begin
        check_val("post_rst_first", 32'(m_ready), 32'b001);
        found = 1;
        break;
      end
    end
    check_val("post_rst_seen", 32'(found), 32'd1);
    m_valid = '0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
